// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU under test: sequences its reset, watches for program end
// (ecall, PC self-loop or timeout), freezes it and streams the register file out.
module cpu_run_ctrl #(
    parameter int          XLEN        = 32,
    parameter int          NREGS       = 32,
    parameter int          AW          = 5,
    parameter int          RST_CYCLES  = 4,
    parameter int          TIMEOUT     = 1000,
    parameter logic [31:0] HALT_INSTR  = 32'h0000_0073,
    parameter int          STALL_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            cpu_rst,
    output logic            cpu_hold,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    output logic [AW-1:0]   reg_addr,
    input  logic [XLEN-1:0] reg_data,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            done,
    output logic [1:0]      status,
    output logic [31:0]     cycle_count
);

    // One-hot so every state-derived output is a plain flop bit.
    typedef enum logic [3:0] {
        S_HOLD = 4'b0001,
        S_RUN  = 4'b0010,
        S_DUMP = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t          state_q, state_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0] prev_pc_q, prev_pc_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      status_q, status_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            dump_valid_q, dump_valid_d;
    logic            done_q, done_d;

    logic [31:0]     stall_next;
    logic            hit_ecall, hit_stall, hit_timeout;

    // cycle_count is still 0 during the first RUN cycle, which is excluded from stall detection.
    assign stall_next  = (cycle_count_q != 32'd0 && pc == prev_pc_q) ? stall_cnt_q + 32'd1 : 32'd0;
    assign hit_ecall   = (instr == HALT_INSTR);
    assign hit_stall   = (stall_next == 32'(STALL_LIMIT - 1));
    assign hit_timeout = (cycle_count_q == 32'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= 8'd0;
            cycle_count_q <= 32'd0;
            stall_cnt_q   <= 32'd0;
            prev_pc_q     <= '0;
            idx_q         <= '0;
            status_q      <= 2'd0;
            cpu_rst_q     <= 1'b1;
            cpu_hold_q    <= 1'b0;
            dump_valid_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            stall_cnt_q   <= stall_cnt_d;
            prev_pc_q     <= prev_pc_d;
            idx_q         <= idx_d;
            status_q      <= status_d;
            cpu_rst_q     <= cpu_rst_d;
            cpu_hold_q    <= cpu_hold_d;
            dump_valid_q  <= dump_valid_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        stall_cnt_d   = stall_cnt_q;
        prev_pc_d     = prev_pc_q;
        idx_d         = idx_q;
        status_d      = status_q;
        unique case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == 8'(RST_CYCLES - 1)) begin
                    state_d     = S_RUN;
                    prev_pc_d   = pc;
                    stall_cnt_d = 32'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                cycle_count_d = cycle_count_q + 32'd1;
                prev_pc_d     = pc;
                stall_cnt_d   = stall_next;
                if (hit_ecall)        status_d = 2'd1;
                else if (hit_stall)   status_d = 2'd2;
                else if (hit_timeout) status_d = 2'd3;
                if (hit_ecall || hit_stall || hit_timeout) state_d = S_DUMP;
            end
            S_DUMP: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) state_d = S_DONE;
                    else                   idx_d   = idx_q + AW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops alongside it.
    always_comb begin
        cpu_rst_d    = (state_d == S_HOLD);
        cpu_hold_d   = (state_d == S_DUMP) || (state_d == S_DONE);
        dump_valid_d = (state_d == S_DUMP);
        done_d       = (state_d == S_DONE);
    end

    assign cpu_rst     = cpu_rst_q;
    assign cpu_hold    = cpu_hold_q;
    assign dump_valid  = dump_valid_q;
    assign done        = done_q;
    assign status      = status_q;
    assign cycle_count = cycle_count_q;
    assign reg_addr    = idx_q;
    assign dump_idx    = idx_q;
    assign dump_data   = reg_data;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a tiny addi/jal/ecall CPU harness, a program-level reference
// model filling a beat scoreboard, and a monitor that checks each dump beat as it transfers.
module tb_cpu_run_ctrl;

    localparam int          NREGS = 32;
    localparam int          RSTC  = 4;
    localparam int          TMO   = 20;
    localparam int          SLIM  = 4;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] JSELF = 32'h0000_006f;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rst, cpu_hold, dump_valid, done;
    logic        dump_ready = 1'b0;
    logic [31:0] pc, instr, reg_data, dump_data, cycle_count;
    logic [4:0]  reg_addr, dump_idx;
    logic [1:0]  status;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .XLEN(32), .NREGS(NREGS), .AW(5), .RST_CYCLES(RSTC), .TIMEOUT(TMO),
        .HALT_INSTR(ECALL), .STALL_LIMIT(SLIM)
    ) dut (
        .clk(clk), .rst(rst), .cpu_rst(cpu_rst), .cpu_hold(cpu_hold),
        .pc(pc), .instr(instr), .reg_addr(reg_addr), .reg_data(reg_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .done(done), .status(status), .cycle_count(cycle_count)
    );

    // ---------------- CPU harness ----------------
    logic [31:0] imem [64];
    logic [31:0] regs [32];
    logic [31:0] cpu_pc = 32'd0;
    logic [31:0] cur_ins;
    logic        ovr = 1'b0, ovr_ecall = 1'b0;
    int          run_k = 0;

    assign cur_ins = imem[cpu_pc[7:2]];

    always @(posedge clk) begin
        if (cpu_rst) begin
            cpu_pc <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (!cpu_hold) begin
            if (cur_ins[6:0] == 7'h13) begin
                if (cur_ins[11:7] != 5'd0)
                    regs[cur_ins[11:7]] <= regs[cur_ins[19:15]] + {{20{cur_ins[31]}}, cur_ins[31:20]};
                cpu_pc <= cpu_pc + 32'd4;
            end else if (cur_ins != JSELF) begin
                cpu_pc <= cpu_pc + 32'd4;
            end
        end
    end

    // Override schedule: PC walks for 16 run cycles then parks at 0x40; optional ecall on cycle 20.
    always @(posedge clk) begin
        if (cpu_rst)        run_k <= 0;
        else if (!cpu_hold) run_k <= run_k + 1;
    end
    assign pc       = ovr ? ((run_k < 16) ? 32'(4 * run_k) : 32'd64) : cpu_pc;
    assign instr    = ovr ? ((ovr_ecall && run_k == 19) ? ECALL : NOP) : cur_ins;
    assign reg_data = regs[reg_addr];

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic [1:0]  st;
        logic [31:0] cc;
    } beat_t;

    beat_t       sb[$];
    beat_t       mon_e;
    int          checks = 0, failures = 0, beats_seen = 0, ready_pct = 100;
    logic        held_v = 1'b0, done_prev = 1'b0;
    logic [4:0]  held_idx;
    logic [31:0] held_data;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("idx_eq_addr", 64'(dump_idx), 64'(reg_addr));
            if (held_v && dump_valid) begin
                chk("stall_idx", 64'(dump_idx), 64'(held_idx));
                chk("stall_data", 64'(dump_data), 64'(held_data));
            end
            if (dump_valid && dump_ready) begin
                beats_seen++;
                if (sb.size() == 0) begin
                    chk("extra_beat", 64'(dump_idx), 64'hFFFF);
                end else begin
                    mon_e = sb.pop_front();
                    chk("beat_idx", 64'(dump_idx), 64'(mon_e.idx));
                    chk("beat_data", 64'(dump_data), 64'(mon_e.data));
                    chk("beat_status", 64'(status), 64'(mon_e.st));
                    chk("beat_cycles", 64'(cycle_count), 64'(mon_e.cc));
                end
            end
            held_v    = dump_valid && !dump_ready;
            held_idx  = dump_idx;
            held_data = dump_data;
            if (done && !done_prev) chk("done_beats_left", 64'(sb.size()), 64'd0);
            done_prev = done;
        end else begin
            held_v    = 1'b0;
            done_prev = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 dump_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // ---------------- stimulus ----------------
    logic [4:0]  op_rd  [64];
    logic [4:0]  op_rs1 [64];
    logic [11:0] op_imm [64];

    task automatic rand_prog();
        for (int i = 0; i < 64; i++) begin
            op_rd[i]  = 5'($urandom_range(0, 31));
            op_rs1[i] = 5'($urandom_range(0, 31));
            op_imm[i] = 12'($urandom);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_cpu_hold", 64'(cpu_hold), 64'd0);
        chk("rst_valid", 64'(dump_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_cycles", 64'(cycle_count), 64'd0);
        chk("rst_idx", 64'(dump_idx), 64'd0);
        chk("rst_addr", 64'(reg_addr), 64'd0);
    endtask

    // kind: 0 ecall at n, 1 jal-self at n, 2 timeout, 3 override triple tie, 4 override stall+timeout
    task automatic run_case(input int kind, input int n, input int pct, input int abort_after,
                            input bit measure_stall, input bit check_pc);
        logic [31:0] exp_regs [32];
        int          m, cc, hc, cyc, first8, stat_at, b0;
        logic [1:0]  st;
        beat_t       b;

        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        ready_pct = pct;
        ovr       = (kind >= 3);
        ovr_ecall = (kind == 3);
        for (int i = 0; i < 64; i++) begin
            if (kind >= 3)                  imem[i] = NOP;
            else if (kind == 0 && i == n)   imem[i] = ECALL;
            else if (kind == 1 && i == n)   imem[i] = JSELF;
            else imem[i] = {op_imm[i], op_rs1[i], 3'b000, op_rd[i], 7'h13};
        end

        // Reference: which addis retire before the freeze, and the resulting stop report.
        case (kind)
            0:       begin m = n;   st = 2'd1; cc = n + 1;    end
            1:       begin m = n;   st = 2'd2; cc = n + SLIM; end
            2:       begin m = TMO; st = 2'd3; cc = TMO;      end
            3:       begin m = 0;   st = 2'd1; cc = TMO;      end
            default: begin m = 0;   st = 2'd2; cc = TMO;      end
        endcase
        for (int r = 0; r < 32; r++) exp_regs[r] = 32'd0;
        for (int i = 0; i < m; i++)
            if (op_rd[i] != 5'd0)
                exp_regs[op_rd[i]] = exp_regs[op_rs1[i]] + {{20{op_imm[i][11]}}, op_imm[i]};
        for (int r = 0; r < NREGS; r++) begin
            b.idx = 5'(r); b.data = exp_regs[r]; b.st = st; b.cc = 32'(cc);
            sb.push_back(b);
        end

        @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;

        hc = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (cpu_rst) hc++;
            else break;
        end
        chk("cpu_rst_cycles", 64'(hc), 64'(RSTC));

        b0 = beats_seen; cyc = 0; first8 = -1; stat_at = -1;
        while (!done && cyc < 2000 && !(abort_after >= 0 && beats_seen >= b0 + abort_after + 1)) begin
            @(negedge clk);
            #1;
            cyc++;
            if (measure_stall) begin
                if (pc == 32'd8 && first8 < 0) first8 = cyc;
                if (status != 2'd0 && stat_at < 0) begin
                    stat_at = cyc;
                    chk("stall_hold_edge", 64'(cpu_hold), 64'd1);
                end
            end
            if (check_pc && dump_valid) chk("pc_frozen", 64'(pc), 64'(4 * TMO));
        end

        if (cyc >= 2000) begin
            chk("done_wait_expired", 64'd0, 64'd1);
        end else if (abort_after >= 0) begin
            @(posedge clk);
            #1 rst = 1'b1;
            sb.delete();
            @(posedge clk);
            @(negedge clk);
            check_reset_vals();
            $display("case kind=%0d n=%0d aborted after %0d beats", kind, n, beats_seen - b0);
        end else begin
            if (measure_stall) chk("stall_latency", 64'(stat_at - first8), 64'(SLIM));
            chk("done_flag", 64'(done), 64'd1);
            chk("done_valid", 64'(dump_valid), 64'd0);
            chk("done_hold", 64'(cpu_hold), 64'd1);
            chk("done_status", 64'(status), 64'(st));
            chk("done_cycles", 64'(cycle_count), 64'(cc));
            chk("done_beats", 64'(beats_seen - b0), 64'(NREGS));
            repeat (3) @(negedge clk);
            chk("done_sticky", 64'(done), 64'd1);
            $display("case kind=%0d n=%0d ready=%0d%% status=%0d cycles=%0d beats=%0d",
                     kind, n, pct, status, cycle_count, beats_seen - b0);
        end
    endtask

    initial begin
        int kind, n;
        rand_prog();
        repeat (3) @(posedge clk);

        // addi x1,x0,5 ; addi x2,x1,3 ; ecall
        op_rd[0] = 5'd1; op_rs1[0] = 5'd0; op_imm[0] = 12'd5;
        op_rd[1] = 5'd2; op_rs1[1] = 5'd1; op_imm[1] = 12'd3;
        run_case(0, 2, 100, -1, 1'b0, 1'b0);

        rand_prog();
        run_case(1, 2, 100, -1, 1'b1, 1'b0);
        rand_prog();
        run_case(2, 0, 100, -1, 1'b0, 1'b1);
        run_case(3, 0, 100, -1, 1'b0, 1'b0);
        run_case(4, 0, 100, -1, 1'b0, 1'b0);

        rand_prog();
        run_case(0, 7, 30, -1, 1'b0, 1'b0);
        run_case(0, 5, 30, 10, 1'b0, 1'b0);
        run_case(0, 5, 30, -1, 1'b0, 1'b0);
        run_case(0, 19, 60, -1, 1'b0, 1'b0);
        run_case(1, 16, 60, -1, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            rand_prog();
            kind = $urandom_range(0, 2);
            n    = (kind == 0) ? $urandom_range(0, 19) : $urandom_range(0, 16);
            run_case(kind, n, $urandom_range(20, 100), -1, 1'b0, kind == 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised run controller that replaces fixed-delay CPU bring-up and ad-hoc register printing.
- Sequences CPU reset and counts cycles while the CPU runs. Detects program end by one of three events:
  - an ecall instruction;
  - a PC self-loop;
  - a timeout.
- On program end it freezes the CPU, then streams the register file out over a valid/ready port.
- Sits beside `cpu` in simulation and FPGA harnesses; drives the CPU's reset and clock-enable and taps its PC, instruction and regfile debug-read port.

Parameters:
- XLEN, 32, width of PC and register data.
- NREGS, 32, number of registers dumped (indices 0..NREGS-1).
- AW, 5, register address width; must satisfy 2^AW >= NREGS.
- RST_CYCLES, 4, cycles `cpu_rst` is held high after `rst` falls (range 1..255).
- TIMEOUT, 1000, run cycles before forced stop (at least 1).
- HALT_INSTR, 32'h00000073, instruction encoding that ends the run (ecall).
- STALL_LIMIT, 4, consecutive cycles with unchanged PC that count as a halt (at least 2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_rst  out  1  reset to the CPU.
- cpu_hold  out  1  high freezes the CPU; the wrapper ANDs `~cpu_hold` into the CPU clock-enable.
- pc  in  XLEN  current CPU PC.
- instr  in  32  instruction currently fetched at `pc`.
- reg_addr  out  AW  regfile debug read address.
- reg_data  in  XLEN  regfile debug read data, combinational from `reg_addr`.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  dump beat accepted.
- dump_idx  out  AW  register index of the current beat.
- dump_data  out  XLEN  register value of the current beat.
- done  out  1  dump complete.
- status  out  2  stop reason: 0 running/none, 1 ecall, 2 PC stall, 3 timeout.
- cycle_count  out  32  run cycles elapsed.

Behaviour:
- Synchronous reset. While `rst` is high:
  - state goes to HOLD, with the hold counter at 0;
  - `cpu_rst`=1, `cpu_hold`=0, `dump_valid`=0, `done`=0, `status`=0;
  - `cycle_count`=0, dump index=0, `reg_addr`=0;
  - stall counter=0, previous-PC register=0.
- Reset asserted in any state, including mid-dump, aborts immediately to the above. A partial dump is not resumed.
- FSM states: HOLD, RUN, DUMP, DONE.
- HOLD:
  - `cpu_rst`=1; the hold counter increments each cycle after `rst` falls.
  - After RST_CYCLES cycles the FSM goes to RUN, and `cpu_rst` falls on the same edge.
- RUN:
  - `cpu_rst`=0, `cpu_hold`=0; `cycle_count` increments by 1 every cycle.
  - Each cycle the following checks are made on the current `pc` and `instr`:
    - a) `instr`==HALT_INSTR gives status=1;
    - b) `pc`==previous PC: stall counter +1, otherwise stall counter resets to 0. Reaching STALL_LIMIT-1 (i.e. STALL_LIMIT cycles at the same PC) gives status=2;
    - c) `cycle_count`==TIMEOUT-1 gives status=3.
  - If several checks fire in the same cycle, priority is a > b > c.
  - On any hit, on the same edge: `status` is loaded, `cpu_hold`=1, state goes to DUMP, and `cycle_count` stops (its final value includes the stopping cycle).
  - The stall check ignores the first RUN cycle; the previous-PC register is loaded on entry to RUN.
- DUMP:
  - `cpu_hold`=1, `dump_valid`=1, `reg_addr`=`dump_idx`=index, `dump_data`=`reg_data` (combinational passthrough, zero latency).
  - A beat transfers on an edge where `dump_valid` && `dump_ready`; the index then increments.
  - While `dump_ready`=0, index and data are held stable.
  - The transfer with index NREGS-1 moves the FSM to DONE. The index does not wrap.
- DONE:
  - `done`=1, `dump_valid`=0, `cpu_hold`=1; `status` and `cycle_count` hold.
  - The FSM stays in DONE until `rst`.
- All outputs except `reg_addr`/`dump_idx`/`dump_data` are registered.
- `dump_idx` equals `reg_addr` in every state.

Test Plan:
- ecall stop: RST_CYCLES=4; the program `addi x1,x0,5; addi x2,x1,3; ecall` reaches ecall on run cycle 3. Require:
  - `cpu_rst` high for 4 cycles after `rst` falls;
  - `status`=1, `cycle_count`=3;
  - dump beats idx1=0x5, idx2=0x8, all others 0;
  - `done`=1 after 32 beats.
- PC stall: `jal x0,0` at PC 0x8, STALL_LIMIT=4. Require status=2 exactly 4 cycles after PC first reads 0x8, and `cpu_hold`=1 on the same edge.
- Timeout: TIMEOUT=20, straight-line code with no halt. Require status=3, `cycle_count`=20, and the CPU PC frozen while `cpu_hold`=1.
- Priority: ecall at a self-looping PC with the timeout reached the same cycle. Require status=1.
- Backpressure: `dump_ready` random at 30%. Require no beat lost or duplicated, indices 0..31 in order, data stable while stalled, and `done` only after index 31 transfers.
- Reset mid-dump: assert `rst` after beat 10. Require all outputs at reset values the next cycle, and a full rerun producing an identical 32-beat dump.
